peripheral_tap_scheduler: RTL and testbench

Shares one TAP result writer between NUM_REQ self-checking bench monitors. Requesters are round-robin arbitrated, and each granted pass/fail result is numbered 1..plan. Results go out on a valid/ready stream to the TAP writer. The block also keeps pass/fail tallies and flags plan violations, so a multi-checker bench produces one consistent TAP plan.

---
 rtl/peripheral_tap_scheduler.sv | 146 ++++++++++++++
 tb/tb_peripheral_tap_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_tap_scheduler.sv
// Round-robin merges NUM_REQ monitor results into one numbered TAP record stream with pass/fail tallies.
// Latency: 1 cycle from grant to tc_valid_o; one record per cycle while tc_ready_i stays high.
// Backpressure: a stalled record holds its fields and blocks further grants until it is accepted.
module peripheral_tap_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int DESC_W  = 8,
  parameter  int CNT_W   = 16,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [CNT_W-1:0]          plan_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        ok_i,
  input  logic [NUM_REQ*DESC_W-1:0] desc_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      tc_valid_o,
  input  logic                      tc_ready_i,
  output logic [CNT_W-1:0]          tc_num_o,
  output logic                      tc_ok_o,
  output logic [SRC_W-1:0]          tc_src_o,
  output logic [DESC_W-1:0]         tc_desc_o,
  output logic [CNT_W-1:0]          pass_cnt_o,
  output logic [CNT_W-1:0]          fail_cnt_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overflow_o,
  output logic                      plan_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   plan_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   issued_inc;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [SRC_W-1:0]   cand;
  logic [SRC_W-1:0]   gnt_src;
  logic               gnt_any;
  logic [DESC_W-1:0]  gnt_desc;
  logic               gnt_ok;
  logic               grant_allow;
  logic               hs;
  logic               can_start;
  logic               start_go;
  logic               start_zero;

  assign hs          = tc_valid_o & tc_ready_i;
  assign grant_allow = (state_q == S_RUN) && (!tc_valid_o || tc_ready_i);
  assign can_start   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_go    = can_start && start_i && (plan_i != '0);
  assign start_zero  = can_start && start_i && (plan_i == '0);
  assign issued_inc  = issued_q + 1'b1;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);

  // First requester at or after the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_src = '0;
    cand    = '0;
    if (grant_allow) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = SRC_W'((int'(rr_ptr) + i) % NUM_REQ);
        if (!gnt_any && req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_src = cand;
        end
      end
    end
    gnt_o = '0;
    if (gnt_any) gnt_o[gnt_src] = 1'b1;
  end

  always_comb begin
    gnt_desc = '0;
    gnt_ok   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_src == SRC_W'(k)) begin
        gnt_desc = desc_i[k*DESC_W +: DESC_W];
        gnt_ok   = ok_i[k];
      end
    end
  end

  assign rr_next = (gnt_src == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_src + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_go) state_d = S_RUN;
      S_RUN:          if (gnt_any && (issued_inc == plan_q)) state_d = S_DRAIN;
      S_DRAIN:        if (!tc_valid_o || tc_ready_i) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      plan_q     <= '0;
      issued_q   <= '0;
      rr_ptr     <= '0;
      tc_valid_o <= 1'b0;
      tc_num_o   <= '0;
      tc_ok_o    <= 1'b0;
      tc_src_o   <= '0;
      tc_desc_o  <= '0;
      pass_cnt_o <= '0;
      fail_cnt_o <= '0;
      overflow_o <= 1'b0;
      plan_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_zero) plan_err_o <= 1'b1;
      if (start_go) begin
        plan_q     <= plan_i;
        issued_q   <= '0;
        pass_cnt_o <= '0;
        fail_cnt_o <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (hs && tc_ok_o)  pass_cnt_o <= pass_cnt_o + 1'b1;
        if (hs && !tc_ok_o) fail_cnt_o <= fail_cnt_o + 1'b1;
        // Requests arriving once the plan is used up are flagged, never granted.
        if (((state_q == S_DRAIN) || (state_q == S_DONE)) && (req_i != '0))
          overflow_o <= 1'b1;
      end
      if (gnt_any) begin
        tc_valid_o <= 1'b1;
        tc_num_o   <= issued_inc;
        tc_ok_o    <= gnt_ok;
        tc_src_o   <= gnt_src;
        tc_desc_o  <= gnt_desc;
        issued_q   <= issued_inc;
        rr_ptr     <= rr_next;
      end else if (hs) begin
        tc_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_tap_scheduler.sv
// Directed bench for peripheral_tap_scheduler: cycle table plus hand sequences for stalls, overflow, plan errors and reset.
module tb_peripheral_tap_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [15:0] plan_i;
  logic [3:0]  req_i;
  logic [3:0]  ok_i;
  logic [31:0] desc_i;
  logic [3:0]  gnt_o;
  logic        tc_valid_o;
  logic        tc_ready_i;
  logic [15:0] tc_num_o;
  logic        tc_ok_o;
  logic [1:0]  tc_src_o;
  logic [7:0]  tc_desc_o;
  logic [15:0] pass_cnt_o;
  logic [15:0] fail_cnt_o;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;
  logic        plan_err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  peripheral_tap_scheduler #(.NUM_REQ(4), .DESC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .plan_i(plan_i),
    .req_i(req_i), .ok_i(ok_i), .desc_i(desc_i), .gnt_o(gnt_o),
    .tc_valid_o(tc_valid_o), .tc_ready_i(tc_ready_i), .tc_num_o(tc_num_o),
    .tc_ok_o(tc_ok_o), .tc_src_o(tc_src_o), .tc_desc_o(tc_desc_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .busy_o(busy_o),
    .done_o(done_o), .overflow_o(overflow_o), .plan_err_o(plan_err_o)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] plan;
    logic [3:0]  req;
    logic [3:0]  ok;
    logic [31:0] desc;
    logic        ready;
    logic [3:0]  e_gnt;
    logic        e_vld;
    logic [15:0] e_num;
    logic        e_ok;
    logic [1:0]  e_src;
    logic [7:0]  e_desc;
    logic [15:0] e_pass;
    logic [15:0] e_fail;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic start, input logic [15:0] plan, input logic [3:0] req,
    input logic [3:0] ok, input logic [31:0] desc, input logic ready,
    input logic [3:0] e_gnt, input logic e_vld, input logic [15:0] e_num, input logic e_ok,
    input logic [1:0] e_src, input logic [7:0] e_desc, input logic [15:0] e_pass,
    input logic [15:0] e_fail, input logic e_busy, input logic e_done);
    vec_t v;
    v.rst = rst; v.start = start; v.plan = plan; v.req = req; v.ok = ok; v.desc = desc;
    v.ready = ready; v.e_gnt = e_gnt; v.e_vld = e_vld; v.e_num = e_num; v.e_ok = e_ok;
    v.e_src = e_src; v.e_desc = e_desc; v.e_pass = e_pass; v.e_fail = e_fail;
    v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Run 1: single requester, plan 3, results ok/nok/ok.
    vecs.push_back(mk(0,1,3,4'h0,4'h0,32'h0 ,1, 4'h0,0,0,0,0,8'h00, 0,0,0,0));
    vecs.push_back(mk(0,0,0,4'h1,4'h1,32'h05,1, 4'h1,0,0,0,0,8'h00, 0,0,1,0));
    vecs.push_back(mk(0,0,0,4'h1,4'h0,32'h06,1, 4'h1,1,1,1,0,8'h05, 0,0,1,0));
    vecs.push_back(mk(0,0,0,4'h1,4'h1,32'h07,1, 4'h1,1,2,0,0,8'h06, 1,0,1,0));
    vecs.push_back(mk(0,0,0,4'h0,4'h0,32'h0 ,1, 4'h0,1,3,1,0,8'h07, 1,1,1,0));
    vecs.push_back(mk(0,0,0,4'h0,4'h0,32'h0 ,1, 4'h0,0,0,0,0,8'h00, 2,1,0,1));
    // Reset from DONE clears everything including the RR pointer.
    vecs.push_back(mk(1,0,0,4'h0,4'h0,32'h0 ,1, 4'h0,0,0,0,0,8'h00, 0,0,0,0));
    // Run 2: all four requesters held, plan 8.
    vecs.push_back(mk(0,1,8,4'hF,4'h5,32'h33221100,1, 4'h0,0,0,0,0,8'h00, 0,0,0,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h1,0,0,0,0,8'h00, 0,0,1,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h2,1,1,1,0,8'h00, 0,0,1,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h4,1,2,0,1,8'h11, 1,0,1,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h8,1,3,1,2,8'h22, 1,1,1,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h1,1,4,0,3,8'h33, 2,1,1,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h2,1,5,1,0,8'h00, 2,2,1,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h4,1,6,0,1,8'h11, 3,2,1,0));
    vecs.push_back(mk(0,0,0,4'hF,4'h5,32'h33221100,1, 4'h8,1,7,1,2,8'h22, 3,3,1,0));
    vecs.push_back(mk(0,0,0,4'h0,4'h5,32'h33221100,1, 4'h0,1,8,0,3,8'h33, 4,3,1,0));
    vecs.push_back(mk(0,0,0,4'h0,4'h0,32'h0       ,1, 4'h0,0,0,0,0,8'h00, 4,4,0,1));

    rst_n = 1'b0; start_i = 1'b0; plan_i = '0; req_i = '0; ok_i = '0;
    desc_i = '0; tc_ready_i = 1'b1;
    #12;
    chk("reset valid", 32'(tc_valid_o), 0);
    chk("reset busy",  32'(busy_o), 0);
    chk("reset done",  32'(done_o), 0);
    chk("reset num",   32'(tc_num_o), 0);
    chk("reset flags", 32'({overflow_o, plan_err_o}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      rst_n = ~vecs[i].rst;
      start_i = vecs[i].start; plan_i = vecs[i].plan; req_i = vecs[i].req;
      ok_i = vecs[i].ok; desc_i = vecs[i].desc; tc_ready_i = vecs[i].ready;
      #2;
      chk($sformatf("row%0d gnt", i),   32'(gnt_o),      32'(vecs[i].e_gnt));
      chk($sformatf("row%0d valid", i), 32'(tc_valid_o), 32'(vecs[i].e_vld));
      chk($sformatf("row%0d pass", i),  32'(pass_cnt_o), 32'(vecs[i].e_pass));
      chk($sformatf("row%0d fail", i),  32'(fail_cnt_o), 32'(vecs[i].e_fail));
      chk($sformatf("row%0d busy", i),  32'(busy_o),     32'(vecs[i].e_busy));
      chk($sformatf("row%0d done", i),  32'(done_o),     32'(vecs[i].e_done));
      chk($sformatf("row%0d ovf", i),   32'(overflow_o), 0);
      if (vecs[i].e_vld) begin
        chk($sformatf("row%0d num", i),  32'(tc_num_o),  32'(vecs[i].e_num));
        chk($sformatf("row%0d ok", i),   32'(tc_ok_o),   32'(vecs[i].e_ok));
        chk($sformatf("row%0d src", i),  32'(tc_src_o),  32'(vecs[i].e_src));
        chk($sformatf("row%0d desc", i), 32'(tc_desc_o), 32'(vecs[i].e_desc));
      end
    end
    rst_n = 1'b1;

    // Backpressure: record 1 stalls for 5 cycles, no grants meanwhile.
    tick(); start_i = 1; plan_i = 2; req_i = 4'h1; ok_i = 4'h1; desc_i = 32'hA0; tc_ready_i = 0;
    #2 chk("bp idle gnt", 32'(gnt_o), 0);
    tick(); start_i = 0;
    #2 chk("bp first gnt", 32'(gnt_o), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick(); ok_i = 4'h0; desc_i = 32'hA1;
      #2;
      chk($sformatf("bp stall%0d gnt", k),   32'(gnt_o), 0);
      chk($sformatf("bp stall%0d valid", k), 32'(tc_valid_o), 1);
      chk($sformatf("bp stall%0d num", k),   32'(tc_num_o), 1);
      chk($sformatf("bp stall%0d ok", k),    32'(tc_ok_o), 1);
      chk($sformatf("bp stall%0d desc", k),  32'(tc_desc_o), 32'hA0);
    end
    tick(); tc_ready_i = 1;
    #2 chk("bp release gnt", 32'(gnt_o), 32'h1);
    chk("bp release num", 32'(tc_num_o), 1);
    tick(); req_i = 0;
    #2 chk("bp rec2 valid", 32'(tc_valid_o), 1);
    chk("bp rec2 num",  32'(tc_num_o), 2);
    chk("bp rec2 ok",   32'(tc_ok_o), 0);
    chk("bp rec2 desc", 32'(tc_desc_o), 32'hA1);
    tick();
    #2 chk("bp done", 32'(done_o), 1);
    chk("bp pass", 32'(pass_cnt_o), 1);
    chk("bp fail", 32'(fail_cnt_o), 1);

    // Overflow: req1 shows up once both plan slots are used.
    tick(); start_i = 1; plan_i = 2; req_i = 4'h1; ok_i = 4'h1; desc_i = 32'hB0;
    tick(); start_i = 0;
    #2 chk("ovf gnt1", 32'(gnt_o), 32'h1);
    tick();
    #2 chk("ovf gnt2", 32'(gnt_o), 32'h1);
    tick(); req_i = 4'h2;
    #2 chk("ovf drain gnt", 32'(gnt_o), 0);
    tick();
    #2 chk("ovf done gnt", 32'(gnt_o), 0);
    chk("ovf flag", 32'(overflow_o), 1);
    chk("ovf done", 32'(done_o), 1);
    chk("ovf total", 32'(pass_cnt_o) + 32'(fail_cnt_o), 2);

    // New start clears overflow; reset mid-record drops everything at once.
    tick(); start_i = 1; plan_i = 3; req_i = 4'h1; desc_i = 32'hC0;
    tick(); start_i = 0;
    #2 chk("rerun ovf clear", 32'(overflow_o), 0);
    chk("rerun busy", 32'(busy_o), 1);
    chk("rerun gnt", 32'(gnt_o), 32'h1);
    tick();
    #2 chk("pre-reset valid", 32'(tc_valid_o), 1);
    rst_n = 0;
    #1 chk("async valid", 32'(tc_valid_o), 0);
    chk("async busy", 32'(busy_o), 0);
    chk("async gnt",  32'(gnt_o), 0);
    chk("async num",  32'(tc_num_o), 0);
    chk("async cnts", 32'({pass_cnt_o, fail_cnt_o}), 0);
    tick(); rst_n = 1; req_i = 0;

    // Zero plan is rejected, then a plan of 1 runs normally.
    tick(); start_i = 1; plan_i = 0;
    tick(); start_i = 0;
    #2 chk("perr flag", 32'(plan_err_o), 1);
    chk("perr busy", 32'(busy_o), 0);
    chk("perr done", 32'(done_o), 0);
    tick(); start_i = 1; plan_i = 1; req_i = 4'h4; ok_i = 4'h4; desc_i = 32'h00D20000;
    #2 chk("p1 idle gnt", 32'(gnt_o), 0);
    tick(); start_i = 0;
    #2 chk("p1 gnt", 32'(gnt_o), 32'h4);
    tick(); req_i = 0;
    #2 chk("p1 num",  32'(tc_num_o), 1);
    chk("p1 src",  32'(tc_src_o), 2);
    chk("p1 ok",   32'(tc_ok_o), 1);
    chk("p1 desc", 32'(tc_desc_o), 32'hD2);
    tick();
    #2 chk("p1 done", 32'(done_o), 1);
    chk("p1 pass", 32'(pass_cnt_o), 1);
    chk("p1 fail", 32'(fail_cnt_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
